// File: rtl/ahb_lite_master_port_if.sv
// Request/response stream and AHB-Lite bus signals of the master port.
// The master modport is the port's own view; the slave modport is the core plus bus fabric.
interface ahb_lite_master_port_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      input  req_valid, req_addr, req_write, req_size, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      input  HREADY, HRESP, HRDATA
   );

   modport slave (
      output req_valid, req_addr, req_write, req_size, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
      output HREADY, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb_lite_master_port.sv
// AHB-Lite single-transfer master: valid/ready requests -> pipelined NONSEQ transfers, 2-cycle min latency.
// req_ready drops while the address phase is stalled by HREADY or an ERROR; responses are never backpressured.
module ahb_lite_master_port #(
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   ahb_lite_master_port_if.master  bus
);
   logic        a_v_q, a_v_d;
   logic [31:0] a_addr_q, a_addr_d;
   logic        a_write_q, a_write_d;
   logic [2:0]  a_size_q, a_size_d;
   logic [31:0] a_wdata_q, a_wdata_d;
   logic        d_v_q, d_v_d;
   logic [1:0]  d_addr_lo_q, d_addr_lo_d;
   logic        d_write_q, d_write_d;
   logic [1:0]  d_size_q, d_size_d;
   logic [31:0] d_wdata_q, d_wdata_d;
   logic        err2_q, err2_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic        adv;
   logic        accept;
   logic        complete;
   logic [31:0] rd_shift;
   logic [31:0] rd_data;
   logic [2:0]  req_hsize;
   logic [31:0] req_haddr;
   logic [31:0] req_hwdata;

   // The pipeline only moves on a ready edge outside the second ERROR cycle.
   assign adv        = bus.HREADY & ~err2_q;
   assign accept     = bus.req_valid & bus.req_ready;
   assign complete   = d_v_q & bus.HREADY;
   assign bus.req_ready = ~a_v_q | adv;

   assign bus.HADDR  = a_addr_q;
   assign bus.HWRITE = a_write_q;
   assign bus.HSIZE  = a_size_q;
   assign bus.HTRANS = (a_v_q & ~err2_q) ? 2'b10 : 2'b00;
   assign bus.HBURST = 3'b000;
   assign bus.HPROT  = HPROT_VAL;
   assign bus.HWDATA = d_wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;

   always_comb begin
      req_hsize  = bus.req_size[1] ? 3'b010 : {1'b0, bus.req_size};
      req_haddr  = bus.req_size[1] ? {bus.req_addr[31:2], 2'b00} :
                   bus.req_size[0] ? {bus.req_addr[31:1], 1'b0} : bus.req_addr;
      req_hwdata = bus.req_size[1] ? bus.req_wdata :
                   bus.req_size[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
      rd_shift   = bus.HRDATA >> {d_addr_lo_q, 3'b000};
      case (d_size_q)
         2'b00:   rd_data = {24'b0, rd_shift[7:0]};
         2'b01:   rd_data = {16'b0, rd_shift[15:0]};
         default: rd_data = rd_shift;
      endcase
   end

   always_comb begin
      a_v_d       = a_v_q;
      a_addr_d    = a_addr_q;
      a_write_d   = a_write_q;
      a_size_d    = a_size_q;
      a_wdata_d   = a_wdata_q;
      d_v_d       = d_v_q;
      d_addr_lo_d = d_addr_lo_q;
      d_write_d   = d_write_q;
      d_size_d    = d_size_q;
      d_wdata_d   = d_wdata_q;
      if (adv) begin
         d_v_d       = a_v_q;
         d_addr_lo_d = a_addr_q[1:0];
         d_write_d   = a_write_q;
         d_size_d    = a_size_q[1:0];
         d_wdata_d   = a_wdata_q;
         a_v_d       = 1'b0;
      end else if (err2_q & bus.HREADY) begin
         d_v_d = 1'b0;
      end
      if (accept) begin
         a_v_d     = 1'b1;
         a_addr_d  = req_haddr;
         a_write_d = bus.req_write;
         a_size_d  = req_hsize;
         a_wdata_d = req_hwdata;
      end
      // err2 covers the second ERROR cycle and holds if the slave extends it.
      err2_d      = ~bus.HREADY & (err2_q | (d_v_q & bus.HRESP));
      rsp_valid_d = complete;
      rsp_err_d   = complete & bus.HRESP;
      rsp_rdata_d = (complete & ~d_write_q) ? rd_data : 32'b0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_v_q       <= 1'b0;
         a_addr_q    <= 32'b0;
         a_write_q   <= 1'b0;
         a_size_q    <= 3'b0;
         a_wdata_q   <= 32'b0;
         d_v_q       <= 1'b0;
         d_addr_lo_q <= 2'b0;
         d_write_q   <= 1'b0;
         d_size_q    <= 2'b0;
         d_wdata_q   <= 32'b0;
         err2_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'b0;
      end else begin
         a_v_q       <= a_v_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_v_q       <= d_v_d;
         d_addr_lo_q <= d_addr_lo_d;
         d_write_q   <= d_write_d;
         d_size_q    <= d_size_d;
         d_wdata_q   <= d_wdata_d;
         err2_q      <= err2_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end
endmodule

// File: tb/tb_ahb_lite_master_port.sv
// Random requests against an AHB slave model with wait states and ERROR responses;
// every accepted request is predicted from its own fields and checked on bus and response.
module tb_ahb_lite_master_port;
   logic HCLK = 1'b0;
   logic HRESETn;

   ahb_lite_master_port_if bus();

   ahb_lite_master_port #(.HPROT_VAL(4'b0011)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   always #5 HCLK = ~HCLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   localparam int MAXQ = 8192;
   logic [31:0] q_addr  [MAXQ];
   logic [31:0] q_wdata [MAXQ];
   logic [31:0] q_rdata [MAXQ];
   logic        q_write [MAXQ];
   logic [2:0]  q_hsize [MAXQ];
   logic        q_err   [MAXQ];
   int n_acc = 0, n_iss = 0, n_rsp = 0;

   // slave data-phase state
   bit dp_v = 0;
   int dp_idx = 0;
   int dp_wait = 0;
   int dp_errc = 0;
   bit exp_rsp = 0;
   bit drop_req = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = {2'b00, a[31:2]};
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Expected transfer and response, from the request fields alone.
   task automatic model_push(input logic [31:0] addr, input logic wr, input logic [1:0] sz,
                             input logic [31:0] wd);
      int nb;
      logic [31:0] al, rep, mask, word;
      nb   = (sz >= 2) ? 4 : (1 << sz);
      al   = addr - (addr % nb);
      rep  = 32'b0;
      for (int i = 0; i < 4; i++) rep[8*i +: 8] = wd[8*(i % nb) +: 8];
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      word = mem_word(al);
      q_addr[n_acc]  = al;
      q_wdata[n_acc] = rep;
      q_write[n_acc] = wr;
      q_hsize[n_acc] = (sz == 2'd3) ? 3'd2 : {1'b0, sz};
      q_err[n_acc]   = (addr[15:12] == 4'hF);
      q_rdata[n_acc] = wr ? 32'b0 : ((word >> (8 * (al % 4))) & mask);
      n_acc++;
   endtask

   task automatic run_cycles(input int n, input int wait_pct, input int req_pct);
      logic [31:0] r;
      bit completing, errc2, pending, acc, cap_v;
      int cap_idx, cap_wait;
      for (int c = 0; c < n; c++) begin
         @(negedge HCLK);
         check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, exp_rsp});
         if (bus.rsp_valid && n_rsp < n_acc) begin
            check("rsp_rdata", bus.rsp_rdata, q_rdata[n_rsp]);
            check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, q_err[n_rsp]});
            n_rsp++;
         end
         completing = 0;
         errc2 = 0;
         if (dp_v) begin
            if (dp_wait > 0) begin
               bus.HREADY = 1'b0; bus.HRESP = 1'b0; dp_wait--;
            end else if (q_err[dp_idx] && dp_errc == 0) begin
               bus.HREADY = 1'b0; bus.HRESP = 1'b1; dp_errc = 1;
            end else begin
               bus.HREADY = 1'b1; bus.HRESP = q_err[dp_idx];
               errc2 = q_err[dp_idx]; completing = 1;
            end
            bus.HRDATA = mem_word(q_addr[dp_idx]);
            if (q_write[dp_idx]) check("HWDATA", bus.HWDATA, q_wdata[dp_idx]);
         end else begin
            bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
         end
         if (drop_req) begin bus.req_valid = 1'b0; drop_req = 0; end
         if (!bus.req_valid && $urandom_range(99) < req_pct) begin
            r = $urandom;
            bus.req_valid = 1'b1;
            bus.req_write = r[0];
            bus.req_size  = r[2:1];
            bus.req_addr  = {16'h0000, (r[5:3] == 3'd0) ? 4'hF : 4'h1, r[17:6]};
            bus.req_wdata = $urandom;
         end
         #1;
         pending = (n_acc > n_iss);
         check("HTRANS", {30'b0, bus.HTRANS}, (pending && !errc2) ? 32'd2 : 32'd0);
         check("req_ready", {31'b0, bus.req_ready},
               {31'b0, (!pending || (bus.HREADY && !errc2))});
         cap_v = 0; cap_idx = 0; cap_wait = 0;
         if (bus.HREADY && bus.HTRANS == 2'b10 && n_iss < n_acc) begin
            check("HADDR", bus.HADDR, q_addr[n_iss]);
            check("HWRITE", {31'b0, bus.HWRITE}, {31'b0, q_write[n_iss]});
            check("HSIZE", {29'b0, bus.HSIZE}, {29'b0, q_hsize[n_iss]});
            cap_v = 1; cap_idx = n_iss; n_iss++;
            cap_wait = ($urandom_range(99) < wait_pct) ? $urandom_range(2, 1) : 0;
         end
         acc = bus.req_valid && bus.req_ready;
         if (acc) begin
            model_push(bus.req_addr, bus.req_write, bus.req_size, bus.req_wdata);
            drop_req = 1;
         end
         exp_rsp = completing;
         if (bus.HREADY) begin
            dp_v = cap_v; dp_idx = cap_idx; dp_wait = cap_wait; dp_errc = 0;
         end
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_HTRANS"}, {30'b0, bus.HTRANS}, 32'd0);
      check({pfx, "_HADDR"}, bus.HADDR, 32'd0);
      check({pfx, "_HWRITE"}, {31'b0, bus.HWRITE}, 32'd0);
      check({pfx, "_HSIZE"}, {29'b0, bus.HSIZE}, 32'd0);
      check({pfx, "_HWDATA"}, bus.HWDATA, 32'd0);
      check({pfx, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
      check({pfx, "_rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
      check({pfx, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
      check({pfx, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      HRESETn = 1'b0;
      bus.req_valid = 1'b0; bus.req_addr = 32'b0; bus.req_write = 1'b0;
      bus.req_size = 2'b0; bus.req_wdata = 32'b0;
      bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'b0;
      #2;
      check_reset_outputs("rst");
      check("HBURST", {29'b0, bus.HBURST}, 32'd0);
      check("HPROT", {28'b0, bus.HPROT}, 32'd3);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;

      run_cycles(400, 0, 100);
      run_cycles(1200, 30, 70);
      run_cycles(400, 60, 40);

      // reset while a transfer is in flight: it must vanish without a response
      for (int g = 0; g < 50 && !dp_v; g++) run_cycles(1, 30, 100);
      check("inflight_before_reset", {31'b0, dp_v}, 32'd1);
      #1;
      HRESETn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      dp_v = 0; exp_rsp = 0; drop_req = 0;
      n_iss = n_acc; n_rsp = n_acc;
      bus.req_valid = 1'b0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      repeat (2) begin
         @(negedge HCLK);
         check("rst_hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
         check("rst_hold_HTRANS", {30'b0, bus.HTRANS}, 32'd0);
      end
      HRESETn = 1'b1;

      run_cycles(800, 30, 80);
      run_cycles(40, 0, 0);
      check("drained", n_rsp, n_acc);
      check("all_issued", n_iss, n_acc);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
